// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, branch flushes, data-memory wait freeze
// with timeout, and EX forwarding selects. Define HAZARD_CTRL_STATS_EN to add o_stall_cnt.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic [4:0]       i_ex_rs,
  input  logic [4:0]       i_ex_rt,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_mem_read,
  input  logic [4:0]       i_mem_rd,
  input  logic             i_mem_reg_write,
  input  logic [4:0]       i_wb_rd,
  input  logic             i_wb_reg_write,
  input  logic             i_branch_taken,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_id_ex_en,
  output logic             o_ex_mem_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_mem_wb_bubble,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic             o_mem_err
`ifdef HAZARD_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0] o_stall_cnt
`endif
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] TimeoutVal = WaitW'(MEM_TIMEOUT);

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             flush_pend_q, flush_pend_d;

  logic mem_stall, freeze, timeout, flush, ld_hit, load_use;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] mem_rd,
                                         input logic mem_we, input logic [4:0] wb_rd,
                                         input logic wb_we);
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == src)) begin
      return 2'b10;
    end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  always_comb begin
    mem_stall = i_mem_req & ~i_mem_ready;
    if (state_q == StRun) begin
      freeze = mem_stall;
    end else begin
      freeze = ~i_mem_ready & (wait_cnt_q < TimeoutVal);
    end
    timeout  = (state_q == StMemWait) & ~i_mem_ready & (wait_cnt_q >= TimeoutVal);
    flush    = (i_branch_taken | flush_pend_q) & ~freeze;
    ld_hit   = i_ex_mem_read & (i_ex_rd != 5'd0) & ((i_ex_rd == i_id_rs) | (i_ex_rd == i_id_rt));
    load_use = ld_hit & ~freeze & ~flush;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    // A branch seen while frozen is remembered and replayed on the first unfrozen cycle.
    if (freeze) begin
      flush_pend_d = flush_pend_q | i_branch_taken;
    end else begin
      flush_pend_d = 1'b0;
    end
    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          state_d    = StMemWait;
          wait_cnt_d = WaitW'(1);
        end
      end
      StMemWait: begin
        if (i_mem_ready) begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end else if (timeout) begin
          // A fresh request in the forced-release cycle starts a new wait.
          if (i_mem_req) begin
            state_d    = StMemWait;
            wait_cnt_d = WaitW'(1);
          end else begin
            state_d    = StRun;
            wait_cnt_d = '0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      default: begin
        state_d    = StRun;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StRun;
      wait_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    o_pc_en         = 1'b1;
    o_if_id_en      = 1'b1;
    o_id_ex_en      = 1'b1;
    o_ex_mem_en     = 1'b1;
    o_if_id_flush   = 1'b0;
    o_id_ex_flush   = 1'b0;
    o_mem_wb_bubble = 1'b0;
    o_mem_err       = timeout;
    o_fwd_a = fwd_sel(i_ex_rs, i_mem_rd, i_mem_reg_write, i_wb_rd, i_wb_reg_write);
    o_fwd_b = fwd_sel(i_ex_rt, i_mem_rd, i_mem_reg_write, i_wb_rd, i_wb_reg_write);
    if (freeze) begin
      o_pc_en         = 1'b0;
      o_if_id_en      = 1'b0;
      o_id_ex_en      = 1'b0;
      o_ex_mem_en     = 1'b0;
      o_mem_wb_bubble = 1'b1;
    end else if (flush) begin
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
    end else if (load_use) begin
      o_pc_en       = 1'b0;
      o_if_id_en    = 1'b0;
      o_id_ex_flush = 1'b1;
    end
    // Hold the whole pipeline quiet while reset is asserted.
    if (!i_rst_n) begin
      o_pc_en         = 1'b0;
      o_if_id_en      = 1'b0;
      o_id_ex_en      = 1'b0;
      o_ex_mem_en     = 1'b0;
      o_if_id_flush   = 1'b0;
      o_id_ex_flush   = 1'b0;
      o_mem_wb_bubble = 1'b0;
      o_mem_err       = 1'b0;
      o_fwd_a         = 2'b00;
      o_fwd_b         = 2'b00;
    end
  end

`ifdef HAZARD_CTRL_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
    end else if ((freeze | load_use) && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule
